// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier control unit: FSM encoding,
// default sizing and control-strobe bit positions.
package booth_pkg;

    localparam int BOOTH_WIDTH = 64;
    localparam int BOOTH_CNT_W = 7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_ADD    = 3'd2;
    localparam logic [2:0] ST_SHIFT  = 3'd3;
    localparam logic [2:0] ST_OUT_LO = 3'd4;
    localparam logic [2:0] ST_OUT_HI = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        INIT   = ST_INIT,
        ADD    = ST_ADD,
        SHIFT  = ST_SHIFT,
        OUT_LO = ST_OUT_LO,
        OUT_HI = ST_OUT_HI,
        DONE   = ST_DONE
    } state_t;

    // Bit positions of the strobes when viewed as a c[6:0] vector (c3 unused).
    localparam int C_INIT  = 0;
    localparam int C_ADD   = 1;
    localparam int C_SUB   = 2;
    localparam int C_SHR   = 4;
    localparam int C_OUTLO = 5;
    localparam int C_OUTHI = 6;

    // IDLE and DONE are the only states in which no operation is in flight.
    function automatic logic state_busy(input state_t s);
        return s inside {INIT, ADD, SHIFT, OUT_LO, OUT_HI};
    endfunction

endpackage

// File: rtl/booth_mul_ctrl_if.sv
// Control-unit <-> datapath/ALU signal bundle: start request, Q feedback bits,
// datapath strobes and status.
interface booth_mul_ctrl_if;

    logic start;
    logic q0;
    logic q_m1;
    logic c0;
    logic c1;
    logic c2;
    logic c4;
    logic c5;
    logic c6;
    logic busy;
    logic done;

    // Controller side.
    modport master (
        input  start, q0, q_m1,
        output c0, c1, c2, c4, c5, c6, busy, done
    );

    // Datapath / ALU top-level side.
    modport slave (
        output start, q0, q_m1,
        input  c0, c1, c2, c4, c5, c6, busy, done
    );

endinterface

// File: rtl/booth_iter_cnt.sv
// Booth iteration counter: cleared at operation start, stepped once per
// completed iteration, flags the final iteration (cnt == WIDTH-1).
module booth_iter_cnt #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && !last) begin
            // Holding at WIDTH-1 keeps the counter inside CNT_W even when
            // CNT_W only just covers WIDTH-1; the FSM leaves the loop anyway.
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign last = (cnt_reg == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_mul_ctrl.sv
// Sequencer for the radix-2 Booth multiplier datapath (A, Q, Q(-1), M).
// Optional build macro BOOTH_SKIP_EN: shift directly from ADD when no add/sub is needed.
module booth_mul_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH,
    parameter int CNT_W = BOOTH_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    booth_mul_ctrl_if.master  bus
);

    state_t state_reg;
    state_t state_next;

    logic cnt_clr;
    logic cnt_inc;
    logic cnt_last;

    logic c0_next;
    logic c1_next;
    logic c2_next;
    logic c4_next;
    logic c5_next;
    logic c6_next;
    logic done_next;

    booth_iter_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .last (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // All strobes decode from state_reg (plus q0/q_m1 in ADD), so the async
    // reset drives every output low without waiting for a clock edge.
    always_comb begin
        state_next = state_reg;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        c0_next    = 1'b0;
        c1_next    = 1'b0;
        c2_next    = 1'b0;
        c4_next    = 1'b0;
        c5_next    = 1'b0;
        c6_next    = 1'b0;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                c0_next    = 1'b1;
                cnt_clr    = 1'b1;
                state_next = ADD;
            end
            ADD: begin
                c1_next = ~bus.q0 &  bus.q_m1;
                c2_next =  bus.q0 & ~bus.q_m1;
`ifdef BOOTH_SKIP_EN
                if (bus.q0 == bus.q_m1) begin
                    c4_next    = 1'b1;
                    cnt_inc    = 1'b1;
                    state_next = cnt_last ? OUT_LO : ADD;
                end else begin
                    state_next = SHIFT;
                end
`else
                state_next = SHIFT;
`endif
            end
            SHIFT: begin
                c4_next    = 1'b1;
                cnt_inc    = 1'b1;
                state_next = cnt_last ? OUT_LO : ADD;
            end
            OUT_LO: begin
                c5_next    = 1'b1;
                state_next = OUT_HI;
            end
            OUT_HI: begin
                c6_next    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.c0   = c0_next;
    assign bus.c1   = c1_next;
    assign bus.c2   = c2_next;
    assign bus.c4   = c4_next;
    assign bus.c5   = c5_next;
    assign bus.c6   = c6_next;
    assign bus.done = done_next;
    assign bus.busy = state_busy(state_reg);

endmodule
